ram_reader: RTL and testbench
=============================

// Module: ram_reader
// PURPOSE
//  Read-side master for the ram512 memory: given base address and word count, walks the RAM
//  address bus and streams each word out on a valid/ready port. One word per cycle when not
//  back-pressured. Sits between ram512 (combinational read, clocked write) and any word consumer.
// PARAMETERS
//  ADDR_W  9   RAM address width (512 words)
//  DATA_W  16  RAM word width
//  CNT_W   10  width of count input (must hold 2**ADDR_W)
// PORTS
//  clk       in   1       single clock, all state on rising edge
//  rst_n     in   1       asynchronous, active-low reset
//  start     in   1       begin transfer (sampled only in IDLE)
//  abort     in   1       synchronous cancel of a running transfer
//  base_adr  in   ADDR_W  first RAM address, sampled with start
//  count     in   CNT_W   words to read, sampled with start
//  busy      out  1       transfer in progress (READ or DRAIN)
//  done      out  1       1-cycle pulse after last word accepted downstream
//  mem_adr   out  ADDR_W  RAM address bus
//  mem_load  out  1       RAM write enable; constant 0
//  mem_out   in   DATA_W  RAM read data, valid same cycle as mem_adr
//  m_valid   out  1       output word valid
//  m_data    out  DATA_W  output word
//  m_ready   in   1       consumer accepts word when m_valid & m_ready
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, m_valid=0, m_data=0, mem_adr=0, mem_load=0, remaining=0.
//  - States: IDLE, READ, DRAIN. Output is one registered word stage (m_valid/m_data).
//  - IDLE: start=1 -> mem_adr<=base_adr, remaining<=min(count,512); count==0 -> done pulses
//    next cycle, stay IDLE, no words emitted; else -> READ. start while busy is ignored.
//  - READ: stage "free" = !m_valid | m_ready. When free: m_data<=mem_out, m_valid<=1,
//    mem_adr<=mem_adr+1 (mod 512, 511->0 wraps), remaining<=remaining-1; remaining==1 -> DRAIN.
//    When not free: hold mem_adr, m_data, remaining (no word dropped/duplicated).
//  - DRAIN: m_valid held until m_valid & m_ready; that cycle m_valid<=0, next cycle done=1, ->IDLE.
//  - Latency: start at edge N -> mem_adr=base from N+1 -> m_valid=1 with mem[base] from N+2.
//    Sustained m_ready=1 -> one word per cycle, count words in count cycles after first.
//  - m_data stable while m_valid & !m_ready (AXI-style rule; valid never withdrawn except abort).
//  - abort (any state): next edge -> IDLE, m_valid=0, done not pulsed, mem_adr holds.
//    abort has priority over start and over handshake in the same cycle.
//  - count>512 clamps to 512; addresses wrap, so base+count crossing 511 continues at 0.
//  - Reset asserted mid-transfer: immediate return to reset values, no done pulse.
//  - mem_load is tied 0 in every state; block never writes RAM.
// STRUCTURE
//  - Shared package ram_pkg: ADDR_W, DATA_W, CNT_W, RAM_WORDS=512, state enum
//    rd_state_t {RD_IDLE, RD_READ, RD_DRAIN}.
//  - One sub-module: ram_rd_stage (single-entry valid/ready output register with load/hold/clear).
//  - Top holds FSM, address counter, remaining counter, done pulse register.
// TESTING (bench uses a ram512 model preloaded mem[i]=16'hA000+i)
//  - base=5,count=4, m_ready=1 -> m_data A005..A008 on 4 consecutive cycles; done 1 cycle after.
//  - base=510,count=4 -> words A1FE,A1FF,A000,A001 (wrap); mem_load never 1.
//  - base=0,count=3, m_ready toggles 1,0,0,1,1 -> exactly A000,A001,A002 once each, m_data
//    stable while stalled; done only after third acceptance.
//  - count=0 -> done pulse 1 cycle after start, m_valid never 1; count=1023 -> 512 words emitted.
//  - abort in READ after 2 words -> m_valid=0 next cycle, no done; new start then works normally.
//  - rst_n low mid-transfer (async, off clock edge) -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared widths, reader state encoding and count clamp for the ram512 reader
package ram_pkg;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 10;
  localparam int RAM_WORDS = 512;
  typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_DRAIN} rd_state_t;
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(RAM_WORDS)) ? CNT_W'(RAM_WORDS) : c;
  endfunction
endpackage

// File: rtl/ram_rd_stage.sv
// ram_rd_stage: single-entry valid/ready output register with load, hold and clear
module ram_rd_stage
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr,
  input  logic              ready,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);
  assign free = !valid || ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/ram_reader.sv
// ram_reader: walks ram512 addresses from base_adr for count words and streams them on valid/ready
module ram_reader
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);
  rd_state_t        state, state_n;
  logic [CNT_W-1:0] remaining;
  logic             done_n, ld, free;
  assign busy     = state != RD_IDLE;
  assign mem_load = 1'b0;
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    ld      = 1'b0;
    if (abort) state_n = RD_IDLE;
    else case (state)
      RD_IDLE: begin
        state_n = (start && count != '0) ? RD_READ : RD_IDLE;
        done_n  = start && count == '0;
      end
      RD_READ: begin
        ld      = free;
        state_n = (free && remaining == CNT_W'(1)) ? RD_DRAIN : RD_READ;
      end
      RD_DRAIN: begin
        done_n  = m_valid && m_ready;
        state_n = done_n ? RD_IDLE : RD_DRAIN;
      end
      default: state_n = RD_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RD_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
    end
  end
  // address wraps naturally at ADDR_W bits, so a run crossing 511 continues at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_adr   <= '0;
      remaining <= '0;
    end else if (!abort && state == RD_IDLE && start) begin
      mem_adr   <= base_adr;
      remaining <= clamp_cnt(count);
    end else if (ld) begin
      mem_adr   <= mem_adr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end
  ram_rd_stage u_stage (
    .clk  (clk),
    .rst_n(rst_n),
    .load (ld),
    .clr  (abort),
    .ready(m_ready),
    .d    (mem_out),
    .valid(m_valid),
    .data (m_data),
    .free (free)
  );
endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: directed bench with a word scoreboard against a ram512 model holding A000+i
module tb_ram_reader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
  logic [8:0]  base_adr = '0;
  logic [9:0]  count = '0;
  logic        busy, done, mem_load, m_valid;
  logic [8:0]  mem_adr;
  logic [15:0] mem_out, m_data;
  int          total = 0, passed = 0, failed = 0;
  int          acc = 0, vcnt = 0, dcnt = 0, ml_seen = 0;
  int          snap, snap2;
  logic [15:0] q[$];
  logic [4:0]  pat = 5'b11001;
  always #5 clk = ~clk;
  assign mem_out = 16'hA000 + {7'd0, mem_adr};
  ram_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_adr(base_adr),
    .count(count), .busy(busy), .done(done), .mem_adr(mem_adr), .mem_load(mem_load),
    .mem_out(mem_out), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  always @(negedge clk) begin
    logic [15:0] exp;
    if (mem_load !== 1'b0) ml_seen++;
    if (m_valid) vcnt++;
    if (done) dcnt++;
    exp = (q.size() != 0) ? q[0] : 16'hxxxx;
    if (m_valid && !m_ready) chk("stall_hold", m_data, exp);
    if (m_valid && m_ready) begin
      if (q.size() != 0) void'(q.pop_front());
      acc++;
      chk("sb_word", m_data, exp);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input int b, input int n);
    base_adr = 9'(b);
    count    = 10'(n);
    start    = 1'b1;
    for (int i = 0; i < (n > 512 ? 512 : n); i++) q.push_back(16'hA000 + 16'((b + i) % 512));
    step();
    start = 1'b0;
  endtask
  task automatic wait_done(input int lim, input string tag);
    int i;
    i = 0;
    while (done !== 1'b1 && i < lim) begin
      step();
      i++;
    end
    chk(tag, done, 1);
    step();
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_adr"}, mem_adr, 0);
    chk({tag, "_load"}, mem_load, 0);
  endtask
  initial begin
    #12;
    chk_reset_vals("rst");
    step();
    rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    go(5, 4);
    chk("t1_adr", mem_adr, 5);
    chk("t1_busy", busy, 1);
    chk("t1_nvalid", m_valid, 0);
    step();
    chk("t1_valid", m_valid, 1);
    chk("t1_first", m_data, 16'hA005);
    step(); step(); step();
    chk("t1_last", m_data, 16'hA008);
    step();
    chk("t1_done", done, 1);
    chk("t1_idle", busy, 0);
    step();
    chk("t1_pulse", done, 0);
    chk("t1_empty", q.size(), 0);
    go(510, 4);
    wait_done(20, "t2_done");
    chk("t2_empty", q.size(), 0);
    chk("t2_wrap_adr", mem_adr, 2);
    m_ready = 1'b0;
    snap = acc;
    go(0, 3);
    for (int k = 0; k < 5; k++) begin
      m_ready = pat[k];
      step();
      chk("t3_no_early_done", done, 0);
    end
    m_ready = 1'b1;
    wait_done(10, "t3_done");
    chk("t3_words", acc - snap, 3);
    chk("t3_empty", q.size(), 0);
    snap = vcnt;
    go(40, 0);
    chk("t4_done", done, 1);
    chk("t4_idle", busy, 0);
    step();
    chk("t4_pulse", done, 0);
    step(); step();
    chk("t4_novalid", vcnt - snap, 0);
    snap = acc;
    go(7, 1023);
    wait_done(600, "t4_big_done");
    chk("t4_big_words", acc - snap, 512);
    chk("t4_big_empty", q.size(), 0);
    snap = acc;
    go(100, 10);
    step(); step();
    abort   = 1'b1;
    m_ready = 1'b0;
    step();
    abort = 1'b0;
    chk("t5_valid", m_valid, 0);
    chk("t5_idle", busy, 0);
    chk("t5_adr_hold", mem_adr, 102);
    chk("t5_words", acc - snap, 1);
    q.delete();
    snap2 = dcnt;
    step(); step(); step();
    chk("t5_nodone", dcnt - snap2, 0);
    m_ready = 1'b1;
    go(20, 2);
    wait_done(10, "t5_restart_done");
    chk("t5_restart_empty", q.size(), 0);
    go(300, 20);
    step(); step(); step(); step(); step();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6");
    q.delete();
    snap2 = dcnt;
    step(); step();
    chk("t6_nodone", dcnt - snap2, 0);
    rst_n = 1'b1;
    step();
    chk("mem_load_never", ml_seen, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
